div_dispatch: RTL
=================

# div_dispatch

Request queue and sequencer between the CPU execute stage and the multi-cycle `divider`. It buffers up to DEPTH tagged divide requests and issues them to the divider one at a time with a single-cycle `req` pulse. It captures each result on the divider's `ready` and presents it, in order, to writeback over a valid/ready handshake.

## Interface
- N, 16, operand/result width; must match the divider's N
- DEPTH, 4, request FIFO entries; power of two, ≥2
- TAGW, 3, destination tag width, passed through unchanged
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  queue can accept; = (count < DEPTH)
- in_dividend  in  N  dividend
- in_divisor  in  N  divisor
- in_tag  in  TAGW  request tag
- div_req  out  1  one-cycle issue pulse to divider
- div_dividend  out  N  registered operand, stable from issue until capture
- div_divisor  out  N  registered operand, stable from issue until capture
- div_ready  in  1  divider completion
- div_exception  in  1  divider divide-by-zero flag, sampled with div_ready
- div_q  in  N  divider quotient
- div_r  in  N  divider remainder
- out_valid  out  1  result present
- out_ready  in  1  writeback accepts
- out_q  out  N  quotient
- out_r  out  N  remainder
- out_tag  out  TAGW  tag of the request
- out_exc  out  1  divide-by-zero
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  state ≠ IDLE or count ≠ 0 or out_valid

## Operation
- FIFO: circular, with wr_ptr, rd_ptr and count. Enqueue when in_valid && in_ready. Dequeue happens only on issue. Pointers wrap at DEPTH. Enqueue and dequeue in the same cycle leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE → ISSUE when count ≠ 0 and out_valid = 0. On the transition, pop the head into the operand and tag registers.
- ISSUE, one cycle: div_req = 1. → WAIT. The armed flag is cleared on entry.
- WAIT: armed is set on the first cycle with div_ready = 0. div_ready = 1 is honoured only when armed = 1; a stale ready from the previous operation is ignored.
- On an honoured ready: capture div_q, div_r, div_exception and the tag into the output registers, set out_valid, and → HOLD.
- HOLD: on out_valid && out_ready, clear out_valid. Go to ISSUE directly if count ≠ 0 (popping the head on that edge), otherwise go to IDLE.
- Results are delivered strictly in request order. At most one division is in flight.
- Output registers hold their value while out_valid = 1 && out_ready = 0.
- Reset (any time, including mid-division) does the following:
  - state = IDLE, pointers = 0, count = 0, armed = 0
  - div_req = 0, div_dividend = 0, div_divisor = 0
  - out_valid = 0, out_q = 0, out_r = 0, out_tag = 0, out_exc = 0
  - in_ready = 1 and busy = 0 immediately
  - The divider must be reset in the same cycle.

## Timing
- Enqueue to div_req, empty queue and idle FSM: 2 cycles (enqueue edge, IDLE→ISSUE edge, div_req high in ISSUE).
- Capture to out_valid: 1 cycle, registered.
- Back-to-back: out_ready accepted in HOLD gives div_req in the next cycle.
- Divider latency is variable. No timeout is applied.
- in_ready is combinational from count only, with no full-bypass. When count = DEPTH, in_ready = 0 even if an issue occurs that cycle.

## Configuration
- DIV_ZERO_BYPASS_EN is defined:
  - A popped request with divisor = 0 is not sent to the divider. The FSM goes IDLE/HOLD → HOLD directly with no div_req.
  - Output is out_q = {N{1'b1}}, out_r = dividend, out_exc = 1, with out_valid one cycle after the pop.
  - div_exception is ignored.
- DIV_ZERO_BYPASS_EN is undefined:
  - Every request is issued to the divider.
  - out_exc = div_exception sampled at capture; out_q and out_r come from the divider.

## Test plan
The bench uses a behavioural divider model with programmable latency L, which holds ready high until the next req-low cycle.
- 100/7, tag 5, L=10, out_ready=1: div_req pulse once; out_q=14, out_r=2, out_tag=5, out_exc=0 exactly one transaction.
- Fill with 5 requests, DEPTH=4, out_ready=0: in_ready=0 at count=4, 5th held; results later drain in order with tags 0..4.
- Stale ready: model leaves ready=1 for 2 cycles after completion, next request issued → second result not captured until model's new ready after arming.
- 9/0 with DIV_ZERO_BYPASS_EN: no div_req; out_q=0xFFFF, out_r=9, out_exc=1. Without the macro: div_req issued, out_exc follows model's exception=1.
- Backpressure: out_ready low 20 cycles → out_* stable, no new div_req; raise out_ready → next div_req the following cycle.
- rst asserted in WAIT with count=2 → next cycle out_valid=0, count=0, in_ready=1, busy=0, div_req=0.

Source files
------------

// File: rtl/div_dispatch.sv
// div_dispatch: tagged request FIFO in front of one multi-cycle divider; results return in request order.
// Optional macro DIV_ZERO_BYPASS_EN: zero-divisor requests complete locally and never reach the divider.
module div_dispatch #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int TAGW  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_dividend,
    input  logic [N-1:0]            in_divisor,
    input  logic [TAGW-1:0]         in_tag,
    output logic                    div_req,
    output logic [N-1:0]            div_dividend,
    output logic [N-1:0]            div_divisor,
    input  logic                    div_ready,
    input  logic                    div_exception,
    input  logic [N-1:0]            div_q,
    input  logic [N-1:0]            div_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_q,
    output logic [N-1:0]            out_r,
    output logic [TAGW-1:0]         out_tag,
    output logic                    out_exc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [N-1:0]    dividend;
        logic [N-1:0]    divisor;
        logic [TAGW-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    req_t              mem_q [DEPTH];
    req_t              in_req;
    req_t              head;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic [N-1:0]      opa_q, opa_d, opb_q, opb_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic              ov_q, ov_d;
    logic [N-1:0]      oq_q, oq_d, or_q, or_d;
    logic [TAGW-1:0]   ot_q, ot_d;
    logic              oe_q, oe_d;
    logic              push, pop;

    // in_ready depends on occupancy only; a same-cycle pop does not open a slot.
    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;
    assign in_req   = '{dividend: in_dividend, divisor: in_divisor, tag: in_tag};
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_req;
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        pop     = 1'b0;
        opa_d   = opa_q;
        opb_d   = opb_q;
        tag_d   = tag_q;
        ov_d    = ov_q;
        oq_d    = oq_q;
        or_d    = or_q;
        ot_d    = ot_q;
        oe_d    = oe_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !ov_q) pop = 1'b1;
            end
            ISSUE: begin
                armed_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                // A ready left over from the previous divide is ignored until ready has been seen low.
                if (!div_ready) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    ov_d    = 1'b1;
                    oq_d    = div_q;
                    or_d    = div_r;
                    ot_d    = tag_q;
                    oe_d    = div_exception;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ov_q && out_ready) begin
                    ov_d = 1'b0;
                    if (count_q != '0) pop = 1'b1;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            armed_d = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            if (head.divisor == '0) begin
                state_d = HOLD;
                ov_d    = 1'b1;
                oq_d    = '1;
                or_d    = head.dividend;
                ot_d    = head.tag;
                oe_d    = 1'b1;
            end else begin
                opa_d   = head.dividend;
                opb_d   = head.divisor;
                tag_d   = head.tag;
                state_d = ISSUE;
            end
`else
            opa_d   = head.dividend;
            opb_d   = head.divisor;
            tag_d   = head.tag;
            state_d = ISSUE;
`endif
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            armed_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            ov_q     <= 1'b0;
            oq_q     <= '0;
            or_q     <= '0;
            ot_q     <= '0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            armed_q  <= armed_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            tag_q    <= tag_d;
            ov_q     <= ov_d;
            oq_q     <= oq_d;
            or_q     <= or_d;
            ot_q     <= ot_d;
            oe_q     <= oe_d;
        end
    end

    assign div_req      = (state_q == ISSUE);
    assign div_dividend = opa_q;
    assign div_divisor  = opb_q;
    assign out_valid    = ov_q;
    assign out_q        = oq_q;
    assign out_r        = or_q;
    assign out_tag      = ot_q;
    assign out_exc      = oe_q;
    assign count        = count_q;
    assign busy         = (state_q != IDLE) || (count_q != '0) || ov_q;

endmodule
